instr_loader: RTL and testbench

- Writer side of the instruction store. Receives a byte stream from a host or debug port over a valid/ready handshake.
- Packs each pair of bytes into one 9-bit machine-code word.
- Writes the words sequentially into the instruction memory that the fetch stage reads by program counter.
- Runs before the core is released from stall; the core must not fetch while busy=1.

---
 rtl/loader_pkg.sv | 6 +
 rtl/instr_loader.sv | 98 +++++++++
 tb/tb_instr_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state type and widths for the instruction loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, W_LO, W_HI, CHK, DONE, ERR} state_t;
  localparam int INSTR_W = 9;
  localparam int LEN_W = 16;
endpackage

// File: rtl/instr_loader.sv
// instr_loader: packs a length-prefixed byte stream into 9-bit words written to instruction memory; LOADER_CHKSUM_EN adds a trailing XOR checksum byte
module instr_loader
  import loader_pkg::*;
#(
  parameter int D = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               wr_en,
  output logic [D-1:0]       wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int CW = LEN_W + D + 1;
`ifdef LOADER_CHKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t st, nx;
  logic [7:0] lo;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] n_rx;
  logic [D:0] cnt;
  logic acc, idle, last, bad_hi;
  assign acc = rx_valid && rx_ready;
  assign idle = st inside {IDLE, DONE, ERR};
  assign n_rx = {rx_data, len[7:0]};
  assign last = CW'(cnt) + CW'(1) == CW'(len);
  assign bad_hi = |rx_data[7:1];
`ifdef LOADER_CHKSUM_EN
  logic [7:0] sum;
  // running XOR of every accepted byte, restarted by each new session
  always_ff @(posedge clk or posedge reset)
    if (reset) sum <= '0;
    else if (start && idle) sum <= '0;
    else if (acc) sum <= sum ^ rx_data;
`endif
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= IDLE;
    else st <= nx;
  // next-state: advance only on an accepted byte, start only from a quiescent state
  always_comb begin
    nx = st;
    if (start && idle) nx = LEN_LO;
    else if (acc)
      case (st)
        LEN_LO: nx = LEN_HI;
        LEN_HI: nx = n_rx == '0 ? FIN : CW'(n_rx) > (CW'(1) << D) ? ERR : W_LO;
        W_LO:   nx = W_HI;
        W_HI:   nx = bad_hi ? ERR : last ? FIN : W_LO;
`ifdef LOADER_CHKSUM_EN
        CHK:    nx = rx_data == sum ? DONE : ERR;
`endif
        default: nx = st;
      endcase
  end
  // outputs decoded from the registered state, never from rx_valid
  always_comb begin
    rx_ready = st inside {LEN_LO, LEN_HI, W_LO, W_HI, CHK};
    busy = rx_ready;
    done = st == DONE;
    err = st == ERR;
  end
  // length capture, byte pairing and the one-cycle write strobe
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lo <= '0;
      len <= '0;
      cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start && idle) begin
        cnt <= '0;
        wr_addr <= '0;
      end else if (acc) begin
        if (st == LEN_LO) len[7:0] <= rx_data;
        if (st == LEN_HI) len[15:8] <= rx_data;
        if (st == W_LO) lo <= rx_data;
        if (st == W_HI && !bad_hi) begin
          wr_en <= 1'b1;
          wr_data <= {rx_data[0], lo};
          wr_addr <= cnt[D-1:0];
          cnt <= cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized frames against a frame-level model of the instruction loader (honours LOADER_CHKSUM_EN)
module tb_instr_loader;
  localparam int D = 12;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_ready, wr_en, busy, done, err;
  logic [D-1:0] wr_addr;
  logic [8:0] wr_data;
  int n_chk = 0;
  int n_pass = 0;
  int unsigned wq_a[$];
  int unsigned wq_d[$];
  int unsigned wd[$];
  logic [7:0] x;

  instr_loader #(.D(D)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (wr_en) begin
      wq_a.push_back(int'(wr_addr));
      wq_d.push_back(int'(wr_data));
    end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int g, input bit sp);
    int gap;
    gap = g < 0 ? int'($urandom_range(3, 0)) : g;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    check("rx_ready", rx_ready, 1);
    rx_data = b;
    rx_valid = 1'b1;
    start = sp;
    x ^= b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill(input int n);
    wd.delete();
    repeat (n) wd.push_back($urandom_range(511, 0));
  endtask

  task automatic run_frame(input string tag, input int n, input int g, input int bad, input logic [6:0] br, input bit corrupt);
    int k;
    bit e;
    bit hit;
    logic [8:0] w;
    logic [6:0] b7;
    logic [7:0] c;
    wq_a.delete();
    wq_d.delete();
    x = '0;
    hit = bad >= 0 && bad < n && n <= 2**D;
    k = n > 2**D ? 0 : hit ? bad : n;
    e = n > 2**D || hit;
`ifdef LOADER_CHKSUM_EN
    e = e || corrupt;
`endif
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":busy_start"}, busy, 1);
    check({tag, ":done_start"}, done, 0);
    send_byte(n[7:0], g, 1'b0);
    send_byte(n[15:8], g, 1'b0);
    if (n <= 2**D) begin
      for (int i = 0; i < n; i++) begin
        w = 9'(wd[i]);
        send_byte(w[7:0], g, 1'b0);
        if (i == bad) begin
          b7 = br != 0 ? br : 7'($urandom_range(127, 1));
          send_byte({b7, w[8]}, g, 1'b0);
          break;
        end
        send_byte({7'b0, w[8]}, g, $urandom_range(3, 0) == 0);
      end
`ifdef LOADER_CHKSUM_EN
      if (!hit) begin
        c = x ^ (corrupt ? 8'h5A : 8'h00);
        send_byte(c, g, 1'b0);
      end
`endif
    end
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, ":done"}, done, !e);
    check({tag, ":err"}, err, e);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":rx_ready_end"}, rx_ready, 0);
    check({tag, ":nwrites"}, wq_a.size(), k);
    for (int i = 0; i < k && i < wq_a.size(); i++) begin
      check({tag, ":addr"}, wq_a[i], i);
      check({tag, ":data"}, wq_d[i], wd[i]);
    end
  endtask

  initial begin
    logic [8:0] w;
    #12;
    check("rst:rx_ready", rx_ready, 0);
    check("rst:wr_en", wr_en, 0);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:err", err, 0);
    check("rst:wr_addr", wr_addr, 0);
    check("rst:wr_data", wr_data, 0);
    @(negedge clk);
    reset = 1'b0;
    wd = {9'h07E, 9'h066, 9'h17A};
    run_frame("plan3", 3, 0, -1, 7'd0, 1'b0);
    run_frame("plan3_gap", 3, 2, -1, 7'd0, 1'b0);
    wd.delete();
    run_frame("n0", 0, 0, -1, 7'd0, 1'b0);
    wd = {9'h07E, 9'h066, 9'h17A};
    run_frame("badhi", 3, 0, 1, 7'd1, 1'b0);
    run_frame("toolong", 2**D + 1, 0, -1, 7'd0, 1'b0);
    // reset while the second word's high byte is on the wire
    wq_a.delete();
    wq_d.delete();
    x = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd3, 0, 1'b0);
    send_byte(8'd0, 0, 1'b0);
    w = 9'(wd[0]);
    send_byte(w[7:0], 0, 1'b0);
    send_byte({7'b0, w[8]}, 0, 1'b0);
    w = 9'(wd[1]);
    send_byte(w[7:0], 0, 1'b0);
    rx_data = {7'b0, w[8]};
    rx_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("mid_rst:rx_ready", rx_ready, 0);
    check("mid_rst:busy", busy, 0);
    check("mid_rst:wr_en", wr_en, 0);
    check("mid_rst:wr_addr", wr_addr, 0);
    check("mid_rst:wr_data", wr_data, 0);
    check("mid_rst:done", done, 0);
    check("mid_rst:err", err, 0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst:nwrites", wq_a.size(), 1);
    reset = 1'b0;
    fill(4);
    run_frame("after_rst", 4, -1, -1, 7'd0, 1'b0);
    fill(2**D);
    run_frame("full", 2**D, 0, -1, 7'd0, 1'b0);
`ifdef LOADER_CHKSUM_EN
    fill(5);
    run_frame("bad_sum", 5, 0, -1, 7'd0, 1'b1);
`endif
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(10, 1);
      fill(n);
      run_frame("rand", n, -1, $urandom_range(3, 0) == 0 ? int'($urandom_range(n - 1, 0)) : -1, 7'd0, $urandom_range(1, 0) == 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
